// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the divider_unit slice.
// Included by divider_if, div_datapath and divider_unit.
package divider_pkg;
    localparam int DIV_WIDTH  = 8;
    localparam int ITER_COUNT = 8;
    localparam int CNT_WIDTH  = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } state_t;
endpackage

// File: rtl/divider_if.sv
// Operand/result bundle between a caller (master) and divider_unit (slave).
interface divider_if;
    import divider_pkg::*;

    logic                 Run;
    logic [DIV_WIDTH-1:0] Dividend;
    logic [DIV_WIDTH-1:0] Divisor;
    logic [DIV_WIDTH-1:0] Quotient;
    logic [DIV_WIDTH-1:0] Remainder;
    logic                 Busy;
    logic                 Done;
    logic                 Div0;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, Div0
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, Div0
    );
endinterface

// File: rtl/div_datapath.sv
// Restoring-division datapath: A/Q shift registers, divisor register and
// 9-bit trial subtractor; one quotient bit per step.
module div_datapath
    import divider_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);
    // A stays below the divisor after every step, so only its low bits are
    // stored; the 9-bit A is formed by the shift.
    logic [DIV_WIDTH-1:0] acc;
    logic [DIV_WIDTH-1:0] q_reg;
    logic [DIV_WIDTH-1:0] m_reg;
    logic [DIV_WIDTH:0]   acc_shift;
    logic [DIV_WIDTH:0]   trial;

    always_comb begin
        acc_shift = {acc, q_reg[DIV_WIDTH-1]};
        trial     = acc_shift - {1'b0, m_reg};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc   <= '0;
            q_reg <= '0;
            m_reg <= '0;
        end else if (load) begin
            acc   <= '0;
            q_reg <= dividend;
            m_reg <= divisor;
        end else if (step) begin
            if (trial[DIV_WIDTH]) begin
                acc   <= acc_shift[DIV_WIDTH-1:0];
                q_reg <= {q_reg[DIV_WIDTH-2:0], 1'b0};
            end else begin
                acc   <= trial[DIV_WIDTH-1:0];
                q_reg <= {q_reg[DIV_WIDTH-2:0], 1'b1};
            end
        end
    end

    assign quotient  = q_reg;
    assign remainder = acc;
endmodule

// File: rtl/divider_unit.sv
// Multi-cycle 8-bit divider: IDLE -> LOAD -> ITER x8 -> FIX -> DONE.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module divider_unit
    import divider_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset,
    divider_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITER_COUNT - 1);

    state_t               state, state_nxt;
    logic                 run_prev;
    logic                 start;
    logic [DIV_WIDTH-1:0] dvd_r, dvs_r;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] quo_r, rem_r;
    logic                 div0_r;
    logic                 dp_load, dp_step;
    logic [DIV_WIDTH-1:0] dp_quo, dp_rem;
    logic [DIV_WIDTH-1:0] ld_dvd, ld_dvs;
    logic [DIV_WIDTH-1:0] fix_quo, fix_rem;
    logic                 dvs_zero;

    assign start    = (state == IDLE) && bus.Run && !run_prev;
    assign dvs_zero = (dvs_r == '0);

`ifdef SIGNED_DIV_EN
    always_comb begin
        ld_dvd  = dvd_r[DIV_WIDTH-1] ? -dvd_r : dvd_r;
        ld_dvs  = dvs_r[DIV_WIDTH-1] ? -dvs_r : dvs_r;
        fix_quo = (dvd_r[DIV_WIDTH-1] ^ dvs_r[DIV_WIDTH-1]) ? -dp_quo : dp_quo;
        fix_rem = dvd_r[DIV_WIDTH-1] ? -dp_rem : dp_rem;
    end
`else
    always_comb begin
        ld_dvd  = dvd_r;
        ld_dvs  = dvs_r;
        fix_quo = dp_quo;
        fix_rem = dp_rem;
    end
`endif

    div_datapath u_datapath (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (dp_load),
        .step      (dp_step),
        .dividend  (ld_dvd),
        .divisor   (ld_dvs),
        .quotient  (dp_quo),
        .remainder (dp_rem)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (dvs_zero) begin
                    state_nxt = DONE;
                end else begin
                    dp_load   = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                dp_step = 1'b1;
                if (cnt == LAST_ITER) state_nxt = FIX;
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // run_prev resets high so a Run held through Reset is not seen as an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_prev <= 1'b1;
            dvd_r    <= '0;
            dvs_r    <= '0;
            cnt      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            div0_r   <= 1'b0;
        end else begin
            run_prev <= bus.Run;
            if (start) begin
                dvd_r  <= bus.Dividend;
                dvs_r  <= bus.Divisor;
                div0_r <= 1'b0;
            end
            if (state == LOAD)      cnt <= '0;
            else if (state == ITER) cnt <= cnt + 1'b1;
            if (state == LOAD && dvs_zero) begin
                quo_r  <= '1;
                rem_r  <= dvd_r;
                div0_r <= 1'b1;
            end
            if (state == FIX) begin
                quo_r <= fix_quo;
                rem_r <= fix_rem;
            end
        end
    end

    assign bus.Quotient  = quo_r;
    assign bus.Remainder = rem_r;
    assign bus.Div0      = div0_r;
    assign bus.Busy      = (state == LOAD) || (state == ITER) || (state == FIX);
    assign bus.Done      = (state == DONE);
endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port Run  input  1  start request, already synchronized/debounced by the caller; a rising edge starts one operation.
REQ-004 SHALL have port Dividend  input  8  dividend operand.
REQ-005 SHALL have port Divisor  input  8  divisor operand.
REQ-006 SHALL have port Quotient  output  8  registered quotient.
REQ-007 SHALL have port Remainder  output  8  registered remainder.
REQ-008 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse when Quotient/Remainder become valid.
REQ-010 SHALL have port Div0  output  1  high when the last operation had a zero divisor.

Function
REQ-011 SHALL detect a start when Run=1 and the previous Run sample=0, with state IDLE; otherwise Run SHALL be ignored, including edges while Busy or in DONE.
REQ-012 SHALL capture Dividend and Divisor into internal registers on the start cycle; later input changes SHALL NOT affect the operation.
REQ-013 SHALL implement states IDLE -> LOAD -> ITER (exactly 8 cycles, 3-bit counter) -> FIX -> DONE -> IDLE.
REQ-014 SHALL perform restoring division, one quotient bit per ITER cycle (shift {A,Q} left, trial-subtract divisor from 9-bit A, restore on negative, set Q[0] on non-negative).
REQ-015 SHALL assert Done in the 11th cycle after the start cycle (start at n; LOAD n+1; ITER n+2..n+9; FIX n+10; DONE n+11).
REQ-016 SHALL hold Busy=1 in LOAD, ITER and FIX, and Busy=0 in IDLE and DONE.
REQ-017 SHALL update Quotient and Remainder only on entry to DONE and hold them until the next DONE or Reset.
REQ-018 SHALL, on divisor zero detected in LOAD, go directly to DONE (Done at n+2), setting Quotient=8'hFF, Remainder=captured dividend, and Div0=1.
REQ-019 SHALL clear Div0 on the next start and SHALL otherwise hold it.
REQ-020 SHALL treat FIX as a no-op pass-through when SIGNED_DIV_EN is undefined, so latency is identical in both builds.

Reset
REQ-021 SHALL, on Reset, immediately force state IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, Div0=0 and counter=0, aborting any operation in progress.
REQ-022 SHALL reset the previous-Run sample to 1, so that a Run held high through Reset does not start an operation.

Configuration
REQ-023 SHALL support macro SIGNED_DIV_EN: when defined, operands are two's complement, LOAD takes magnitudes, and FIX negates the quotient if the operand signs differ and gives the remainder the dividend's sign (truncation toward zero).
REQ-024 SHALL, with SIGNED_DIV_EN defined, return 8'h80 remainder 0 for 8'h80 / 8'hFF (wrap, no flag).
REQ-025 SHALL, without SIGNED_DIV_EN, treat operands as unsigned.

Structure
REQ-026 SHALL place the state enum typedef, DIV_WIDTH=8 and ITER_COUNT=8 in shared package divider_pkg.
REQ-027 SHALL split the A/Q shift registers and 9-bit subtractor into sub-module div_datapath, with the FSM kept in divider_unit.

Verification
REQ-028 Unsigned build, 8'd200 / 8'd7, Run edge -> Done at n+11, Quotient=8'd28, Remainder=8'd4, Div0=0.
REQ-029 Either build, 8'h55 / 8'h00 -> Done at n+2, Quotient=8'hFF, Remainder=8'h55, Div0=1; the next valid start clears Div0.
REQ-030 SIGNED_DIV_EN defined, 8'hF9 / 8'h02 -> Quotient=8'hFD, Remainder=8'hFF; unsigned build, same inputs -> Quotient=8'h7C, Remainder=8'h01.
REQ-031 Reset asserted during the 4th ITER cycle with Run held high -> outputs 0 and IDLE asynchronously; no restart until Run falls and rises again.
REQ-032 Second Run edge at n+5 with changed operands -> ignored; result matches the first operands; exactly one Done pulse.
